// File: rtl/word_buffer_ctrl_pkg.sv
// Shared types and constants for the word buffer controller.
// Holds the FSM state enum, frame/word/buffer widths and a partial-word test helper.
// Imported by the interface, the starvation timer and the top.
package word_buffer_ctrl_pkg;

   localparam int FRAME_W    = 40;
   localparam int WORD_W     = 32;
   localparam int BUF_BITS   = 256;
   // Wide enough to hold BUF_BITS itself (a completely full buffer).
   localparam int BITS_CNT_W = $clog2(BUF_BITS) + 1;

   typedef logic [BITS_CNT_W-1:0] bits_cnt_t;

   localparam bits_cnt_t WORD_BITS = bits_cnt_t'(WORD_W);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PARTIAL = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   // True when the buffer holds some bits but not enough for a full word.
   function automatic logic is_partial(input bits_cnt_t bits);
      return (bits != '0) && (bits < WORD_BITS);
   endfunction

endpackage

// File: rtl/word_buffer_ctrl_if.sv
// Bus bundle between the controller, the upstream frame source, the word buffer and the word sink.
// Ports: frame_valid/frame_data/frame_ready, buf_wren/buf_din/buf_rden, buf_dout/buf_bits_count/
//        buf_almost_empty/buf_almost_full, word_out/word_valid/word_ready.
// master = controller side, slave = environment side (source, buffer and sink).
interface word_buffer_ctrl_if;
   import word_buffer_ctrl_pkg::*;

   // upstream frames
   logic               frame_valid;
   logic [FRAME_W-1:0] frame_data;
   logic               frame_ready;

   // word buffer strobes and status
   logic               buf_wren;
   logic [FRAME_W-1:0] buf_din;
   logic               buf_rden;
   logic [WORD_W-1:0]  buf_dout;
   bits_cnt_t          buf_bits_count;
   logic               buf_almost_empty;
   logic               buf_almost_full;

   // downstream words
   logic [WORD_W-1:0]  word_out;
   logic               word_valid;
   logic               word_ready;

   modport master (
      input  frame_valid, frame_data,
      output frame_ready,
      output buf_wren, buf_din, buf_rden,
      input  buf_dout, buf_bits_count, buf_almost_empty, buf_almost_full,
      output word_out, word_valid,
      input  word_ready
   );

   modport slave (
      output frame_valid, frame_data,
      input  frame_ready,
      input  buf_wren, buf_din, buf_rden,
      output buf_dout, buf_bits_count, buf_almost_empty, buf_almost_full,
      input  word_out, word_valid,
      output word_ready
   );

endinterface

// File: rtl/wbc_starve_timer.sv
// Write-starvation timer: counts cycles a partial word sits in the buffer untouched.
// Latency: timeout is a compare on the registered count, valid the cycle the count reaches FLUSH_TIMEOUT.
// Backpressure: none; it only observes strobes. Ports: clk, rst, wren, rden, bits_count in; timeout out.
module wbc_starve_timer
   import word_buffer_ctrl_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = 64,
   parameter int TIMEOUT_W     = 8
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      wren,
   input  logic      rden,
   input  bits_cnt_t bits_count,
   output logic      timeout
);

   localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(FLUSH_TIMEOUT);

   logic [TIMEOUT_W-1:0] cnt;
   logic                 clear;

   // Any buffer activity, or a buffer that is empty or holds a full word, restarts the wait.
   assign clear = wren | rden | ~is_partial(bits_count);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (cnt != LIMIT) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/word_buffer_ctrl.sv
// Repacks 40-bit frames into 32-bit words through an external bit buffer, flushing partial words.
// Latency: 1 cycle from buf_rden to word_valid; partial words after flush or FLUSH_TIMEOUT idle cycles.
// Backpressure: frame_ready drops on buf_almost_full or outside RUN; reads stall while word_out is held.
// Ports: clk, rst (async, active-high), enable, flush, busy, bus (word_buffer_ctrl_if.master).
// Optional WORD_BUFFER_CTRL_STATS_EN adds frame_cnt, word_cnt and partial_cnt outputs.
module word_buffer_ctrl
   import word_buffer_ctrl_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = 64,
   parameter int TIMEOUT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               flush,
   output logic               busy,
   word_buffer_ctrl_if.master bus
`ifdef WORD_BUFFER_CTRL_STATS_EN
   ,
   output logic [31:0]        frame_cnt,
   output logic [31:0]        word_cnt,
   output logic [15:0]        partial_cnt
`endif
);

   state_t            state;
   logic              ret_drain;   // PARTIAL goes back to DRAIN rather than RUN
   logic [WORD_W-1:0] word_q;
   logic              word_vld_q;

   logic out_free;
   logic has_partial;
   logic buf_empty;
   logic rden;
   logic wren;
   logic timeout;

   assign out_free    = ~word_vld_q | bus.word_ready;
   assign has_partial = is_partial(bus.buf_bits_count);
   assign buf_empty   = (bus.buf_bits_count == '0);

   assign bus.frame_ready = (state == ST_RUN) & ~bus.buf_almost_full;
   assign wren            = bus.frame_valid & bus.frame_ready;
   assign bus.buf_wren    = wren;
   assign bus.buf_din     = bus.frame_data;

   // The single partial read is issued only while bits remain; an empty buffer just exits PARTIAL.
   always_comb begin
      rden = 1'b0;
      case (state)
         ST_RUN, ST_DRAIN: rden = out_free & ~bus.buf_almost_empty;
         ST_PARTIAL:       rden = out_free & ~buf_empty;
         default:          rden = 1'b0;
      endcase
   end

   assign bus.buf_rden = rden;

   wbc_starve_timer #(
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT),
      .TIMEOUT_W     (TIMEOUT_W)
   ) u_starve_timer (
      .clk        (clk),
      .rst        (rst),
      .wren       (wren),
      .rden       (rden),
      .bits_count (bus.buf_bits_count),
      .timeout    (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ret_drain <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  state <= ST_DRAIN;
               end else if (has_partial && (flush || timeout)) begin
                  state     <= ST_PARTIAL;
                  ret_drain <= 1'b0;
               end
            end
            ST_PARTIAL: begin
               if (rden || buf_empty) begin
                  state <= ret_drain ? ST_DRAIN : ST_RUN;
               end
            end
            ST_DRAIN: begin
               // Leave only once every buffered bit has been handed downstream.
               if (buf_empty && !word_vld_q) begin
                  state <= ST_IDLE;
               end else if (has_partial) begin
                  state     <= ST_PARTIAL;
                  ret_drain <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output register: loads only on a read, and reads only happen when it is free,
   // so word_out holds while a word waits for word_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q     <= '0;
         word_vld_q <= 1'b0;
      end else if (rden) begin
         word_q     <= bus.buf_dout;
         word_vld_q <= 1'b1;
      end else if (bus.word_ready) begin
         word_vld_q <= 1'b0;
      end
   end

   assign bus.word_out   = word_q;
   assign bus.word_valid = word_vld_q;
   assign busy           = (state != ST_IDLE);

`ifdef WORD_BUFFER_CTRL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt   <= '0;
         word_cnt    <= '0;
         partial_cnt <= '0;
      end else begin
         if (wren) begin
            frame_cnt <= frame_cnt + 32'd1;
         end
         if (word_vld_q && bus.word_ready) begin
            word_cnt <= word_cnt + 32'd1;
         end
         if (rden && (state == ST_PARTIAL)) begin
            partial_cnt <= partial_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_word_buffer_ctrl.sv
module tb_word_buffer_ctrl;
   import word_buffer_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic flush;
   logic busy;

   word_buffer_ctrl_if bus ();

`ifdef WORD_BUFFER_CTRL_STATS_EN
   logic [31:0] frame_cnt;
   logic [31:0] word_cnt;
   logic [15:0] partial_cnt;
`endif

   word_buffer_ctrl #(
      .FLUSH_TIMEOUT (64),
      .TIMEOUT_W     (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .flush  (flush),
      .busy   (busy),
      .bus    (bus)
`ifdef WORD_BUFFER_CTRL_STATS_EN
      ,
      .frame_cnt   (frame_cnt),
      .word_cnt    (word_cnt),
      .partial_cnt (partial_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Word buffer model: MSB-first bit queue, reads take up to 32 bits (zero padded),
   // a same-cycle write lands behind whatever the read left.
   logic [BUF_BITS-1:0] mem, mem_nxt;
   logic [8:0]          cnt, cnt_nxt;

   always_comb begin
      mem_nxt = mem;
      cnt_nxt = cnt;
      if (bus.buf_rden) begin
         mem_nxt = mem << WORD_W;
         cnt_nxt = (cnt >= 9'd32) ? (cnt - 9'd32) : 9'd0;
      end
      if (bus.buf_wren) begin
         mem_nxt = mem_nxt | ({bus.buf_din, {(BUF_BITS-FRAME_W){1'b0}}} >> cnt_nxt);
         cnt_nxt = cnt_nxt + 9'd40;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '0;
         cnt <= '0;
      end else begin
         mem <= mem_nxt;
         cnt <= cnt_nxt;
      end
   end

   assign bus.buf_dout         = mem[BUF_BITS-1 -: WORD_W];
   assign bus.buf_bits_count   = cnt;
   assign bus.buf_almost_empty = (cnt < 9'd32);
   assign bus.buf_almost_full  = (cnt > 9'd176);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] got_q[$];
   int          got_t[$];
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      if (!rst && bus.word_valid && bus.word_ready) begin
         got_q.push_back(bus.word_out);
         got_t.push_back(cyc);
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [39:0] d, input string tag);
      logic acc;
      acc = 1'b0;
      bus.frame_valid = 1'b1;
      bus.frame_data  = d;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = bus.frame_ready;
         tick();
      end
      check(tag, 64'(acc), 64'd1);
   endtask

   task automatic wait_words(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && got_q.size() < n; i++) tick();
      check(tag, 64'(got_q.size()), 64'(n));
   endtask

   task automatic check_words(input string tag);
      check({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      end
   endtask

   task automatic clear_words();
      got_q.delete();
      got_t.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       acc;
      int         k;
      logic [7:0] b;

      rst             = 1'b1;
      enable          = 1'b0;
      flush           = 1'b0;
      bus.frame_valid = 1'b0;
      bus.frame_data  = '0;
      bus.word_ready  = 1'b0;

      // reset state
      tick(); tick();
      @(negedge clk);
      check("rst_busy",        64'(busy),            64'd0);
      check("rst_frame_ready", 64'(bus.frame_ready), 64'd0);
      check("rst_word_valid",  64'(bus.word_valid),  64'd0);
      check("rst_word_out",    64'(bus.word_out),    64'd0);
      check("rst_buf_rden",    64'(bus.buf_rden),    64'd0);
      tick();
      rst = 1'b0;

      // four back-to-back frames -> five words
      enable         = 1'b1;
      bus.word_ready = 1'b1;
      tick();
      @(negedge clk);
      check("run_busy",        64'(busy),            64'd1);
      check("run_frame_ready", 64'(bus.frame_ready), 64'd1);
      tick();
      send_frame(40'h11_2233_4455, "t1_f0");
      send_frame(40'h66_7788_99AA, "t1_f1");
      send_frame(40'hBB_CCDD_EEFF, "t1_f2");
      send_frame(40'h01_2345_6789, "t1_f3");
      bus.frame_valid = 1'b0;
      wait_words(5, 40, "t1_wait");
      tick(); tick();
      exp_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF01, 32'h23456789};
      check_words("t1");
      check("t1_bits_zero", 64'(cnt), 64'd0);

      // flush with an empty buffer does nothing
      clear_words();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      check("fl0_no_word", 64'(got_q.size()), 64'd0);
      check("fl0_busy",    64'(busy),         64'd1);

      // one frame then starvation -> full word, then timed-out partial word
      clear_words();
      send_frame(40'hA5_1234_5678, "t2_f0");
      bus.frame_valid = 1'b0;
      wait_words(2, 120, "t2_wait");
      exp_q = '{32'hA5123456, 32'h78000000};
      check_words("t2");
      if (got_t.size() >= 2) check("t2_gap", 64'(got_t[1] - got_t[0]), 64'd66);

      // one frame, flush three cycles later
      tick();
      clear_words();
      send_frame(40'hC3_0F0F_0F3C, "t3_f0");
      bus.frame_valid = 1'b0;
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_words(2, 20, "t3_wait");
      exp_q = '{32'hC30F0F0F, 32'h3C000000};
      check_words("t3");
      if (got_t.size() >= 2) check("t3_gap", 64'(got_t[1] - got_t[0]), 64'd3);

      // downstream stalled: frames until almost_full, word_out held
      tick();
      clear_words();
      bus.word_ready  = 1'b0;
      k               = 0;
      b               = 8'h10;
      bus.frame_valid = 1'b1;
      bus.frame_data  = {5{b}};
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc = bus.frame_ready;
         tick();
         if (acc) begin
            k++;
            b              = b + 8'd1;
            bus.frame_data = {5{b}};
         end
      end
      @(negedge clk);
      check("t4_accepted",    64'(k),               64'd6);
      check("t4_frame_ready", 64'(bus.frame_ready), 64'd0);
      check("t4_bits",        64'(cnt),             64'd208);
      check("t4_word_valid",  64'(bus.word_valid),  64'd1);
      check("t4_word_out",    64'(bus.word_out),    64'h10101010);
      tick();
      bus.frame_valid = 1'b0;
      bus.word_ready  = 1'b1;
      wait_words(7, 40, "t4_wait7");
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_words(8, 20, "t4_wait8");
      exp_q = '{32'h10101010, 32'h10111111, 32'h11111212, 32'h12121213,
                32'h13131313, 32'h14141414, 32'h14151515, 32'h15150000};
      check_words("t4");

      // enable falls with 72 bits buffered -> everything drained, then idle
      tick();
      clear_words();
      bus.word_ready = 1'b0;
      send_frame({5{8'h20}}, "t5_f0");
      send_frame({5{8'h21}}, "t5_f1");
      send_frame({5{8'h22}}, "t5_f2");
      send_frame({5{8'h23}}, "t5_f3");
      send_frame({5{8'h24}}, "t5_f4");
      bus.frame_valid = 1'b0;
      bus.word_ready  = 1'b1;
      for (int i = 0; i < 20 && cnt != 9'd72; i++) @(negedge clk);
      check("t5_bits72", 64'(cnt), 64'd72);
      enable = 1'b0;
      wait_words(7, 40, "t5_wait");
      for (int i = 0; i < 20 && busy; i++) tick();
      @(negedge clk);
      exp_q = '{32'h20202020, 32'h20212121, 32'h21212222, 32'h22222223,
                32'h23232323, 32'h24242424, 32'h24000000};
      check_words("t5");
      check("t5_busy",        64'(busy),            64'd0);
      check("t5_frame_ready", 64'(bus.frame_ready), 64'd0);
      check("t5_word_valid",  64'(bus.word_valid),  64'd0);
      check("t5_bits",        64'(cnt),             64'd0);

      // reset while a word is held
      tick();
      enable         = 1'b1;
      bus.word_ready = 1'b0;
      tick();
      send_frame(40'hFE_DCBA_9876, "t6_f0");
      bus.frame_valid = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("t6_word_valid", 64'(bus.word_valid), 64'd1);
      check("t6_word_out",   64'(bus.word_out),   64'hFEDCBA98);
`ifdef WORD_BUFFER_CTRL_STATS_EN
      check("st_frame_cnt",   64'(frame_cnt),   64'd18);
      check("st_word_cnt",    64'(word_cnt),    64'd24);
      check("st_partial_cnt", 64'(partial_cnt), 64'd4);
`endif
      rst = 1'b1;
      #1;
      check("t6_rst_word_valid",  64'(bus.word_valid),  64'd0);
      check("t6_rst_busy",        64'(busy),            64'd0);
      check("t6_rst_word_out",    64'(bus.word_out),    64'd0);
      check("t6_rst_frame_ready", 64'(bus.frame_ready), 64'd0);
      check("t6_rst_buf_rden",    64'(bus.buf_rden),    64'd0);
`ifdef WORD_BUFFER_CTRL_STATS_EN
      check("st_rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
      tick();
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
